// File: rtl/serial_mul_hs.sv
// serial_mul_hs: MSB-first shift-add serial multiplier with a start/busy/done handshake.
// Optional signed mode via `define SERIAL_MUL_SIGNED_EN.
`default_nettype none

module serial_mul_hs #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]           state;
    logic [CW-1:0]        count;
    logic [WIDTH-1:0]     a_reg;
    logic [WIDTH-1:0]     m_reg;
    logic [2*WIDTH-1:0]   acc;

    logic                 accept;
    logic [WIDTH-1:0]     a_in;
    logic [WIDTH-1:0]     b_in;
    logic [2*WIDTH-1:0]   add_term;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   result;

    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign add_term = m_reg[WIDTH-1] ? {{WIDTH{1'b0}}, a_reg} : '0;
    assign acc_next = (acc << 1) + add_term;

`ifdef SERIAL_MUL_SIGNED_EN
    logic sign_reg;

    // Magnitudes are taken in WIDTH bits; the most negative value maps to 2^(WIDTH-1), which fits unsigned.
    assign a_in   = a[WIDTH-1] ? -a : a;
    assign b_in   = b[WIDTH-1] ? -b : b;
    assign result = sign_reg ? -acc_next : acc_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sign_reg <= 1'b0;
        end else if (accept) begin
            sign_reg <= a[WIDTH-1] ^ b[WIDTH-1];
        end
    end
`else
    assign a_in   = a;
    assign b_in   = b;
    assign result = acc_next;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            a_reg <= '0;
            m_reg <= '0;
            acc   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            p     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        a_reg <= a_in;
                        m_reg <= b_in;
                        acc   <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        state <= RUN;
                    end else begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    m_reg <= m_reg << 1;
                    count <= count + 1'b1;
                    // The WIDTH-th iteration publishes its own sum directly into p.
                    if (count == LAST) begin
                        p     <= result;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_mul_hs.sv
// tb_serial_mul_hs: directed, scoreboard-based bench for serial_mul_hs at WIDTH=8.
`default_nettype none

module tb_serial_mul_hs;

    localparam int W = 8;

    logic           clk;
    logic           reset;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] p;

    typedef struct {
        logic [2*W-1:0] p;
        int             cyc;
    } exp_t;

    exp_t sbq[$];
    int   cyc;
    int   n_assert;
    int   n_fail;

    serial_mul_hs #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SERIAL_MUL_SIGNED_EN
        logic signed [2*W-1:0] sx;
        logic signed [2*W-1:0] sy;
        sx = {{W{x[W-1]}}, x};
        sy = {{W{y[W-1]}}, y};
        return 16'(sx * sy);
`else
        return {{W{1'b0}}, x} * {{W{1'b0}}, y};
`endif
    endfunction

    // Done must appear exactly WIDTH edges after its accept and carry the queued product.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sbq.size() == 0) begin
                chk("spurious_done", {31'd0, done}, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("p_at_done", {16'd0, p}, {16'd0, e.p});
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2*W-1:0] exp);
        exp_t e;
        start = 1'b1;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        e.p = exp;
        e.cyc = cyc + W;
        sbq.push_back(e);
        start = 1'b0;
    endtask

    task automatic push_exp(input logic [2*W-1:0] exp);
        exp_t e;
        e.p = exp;
        e.cyc = cyc + W;
        sbq.push_back(e);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (sbq.size() != 0) begin
            chk("drain_timeout", sbq.size(), 32'd0);
            sbq.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_assert = 0;
        n_fail   = 0;
        cyc      = 0;
        reset    = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;

        #2;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_p", {16'd0, p}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 13*11: busy for exactly 8 cycles, then held result
        issue(8'd13, 8'd11, model(8'd13, 8'd11));
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk("busy_run", {31'd0, busy}, 32'd1);
        end
        @(negedge clk);
        chk("busy_end", {31'd0, busy}, 32'd0);
        wait_drain();
        repeat (3) @(posedge clk);
        #1;
        chk("p_held", {16'd0, p}, {16'd0, model(8'd13, 8'd11)});
        chk("done_low", {31'd0, done}, 32'd0);

        // 255*255, with p unchanged mid-run
        issue(8'd255, 8'd255, model(8'd255, 8'd255));
        repeat (3) @(posedge clk);
        #1;
        chk("p_keep_during_run", {16'd0, p}, {16'd0, model(8'd13, 8'd11)});
        wait_drain();
        @(posedge clk);
        #1;
        issue(8'd0, 8'd200, model(8'd0, 8'd200));
        wait_drain();
        @(posedge clk);
        #1;

        // back-to-back with start held: DONE occupies one cycle between operations
        start = 1'b1;
        a = 8'd7;
        b = 8'd9;
        @(posedge clk);
        #1;
        push_exp(model(8'd7, 8'd9));
        a = 8'd100;
        b = 8'd3;
        repeat (W + 1) @(posedge clk);
        #1;
        push_exp(model(8'd100, 8'd3));
        a = 8'd1;
        b = 8'd1;
        repeat (W + 1) @(posedge clk);
        #1;
        push_exp(model(8'd1, 8'd1));
        start = 1'b0;
        wait_drain();
        @(posedge clk);
        #1;

        // start and operand change mid-run are ignored
        issue(8'd5, 8'd6, model(8'd5, 8'd6));
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        a = 8'd99;
        b = 8'd77;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_drain();
        repeat (12) @(posedge clk);
        #1;
        chk("p_after_ignored_start", {16'd0, p}, {16'd0, model(8'd5, 8'd6)});

        // reset mid-operation abandons it
        issue(8'd200, 8'd200, model(8'd200, 8'd200));
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_done", {31'd0, done}, 32'd0);
        chk("midreset_p", {16'd0, p}, 32'd0);
        sbq.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("no_done_after_reset_p", {16'd0, p}, 32'd0);
        issue(8'd2, 8'd3, model(8'd2, 8'd3));
        wait_drain();
        @(posedge clk);
        #1;

`ifdef SERIAL_MUL_SIGNED_EN
        issue(8'hFD, 8'd5, 16'hFFF1);
        wait_drain();
        @(posedge clk);
        #1;
        issue(8'h80, 8'h80, 16'h4000);
        wait_drain();
        @(posedge clk);
        #1;
        issue(8'h80, 8'h7F, 16'hC080);
        wait_drain();
        @(posedge clk);
        #1;
        issue(8'h7F, 8'hFF, 16'hFF81);
        wait_drain();
        @(posedge clk);
        #1;
`endif

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
